// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: ID-side inputs, downstream writer taps and
// EX-side outputs grouped as one interface (master = driver, slave = stage).
interface id_ex_stage_if #(
    parameter int XLEN = 32,
    parameter int REGW = 5,
    parameter int OPW  = 5
);
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [REGW-1:0] id_rs1;
    logic [REGW-1:0] id_rs2;
    logic [REGW-1:0] id_rd;
    logic            id_rs1_used;
    logic            id_rs2_used;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic            id_alusrc;
    logic [OPW-1:0]  id_aluop;
    logic            id_regwrite;
    logic            id_memread;
    logic            id_memwrite;
    logic [1:0]      id_wdsel;
    logic            hold;
    logic            flush;
    logic            exmem_regwrite;
    logic [REGW-1:0] exmem_rd;
    logic [XLEN-1:0] exmem_result;
    logic            memwb_regwrite;
    logic [REGW-1:0] memwb_rd;
    logic [XLEN-1:0] memwb_wdata;
    logic            stall;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_A;
    logic [XLEN-1:0] ex_B;
    logic [XLEN-1:0] ex_store_data;
    logic [OPW-1:0]  ex_aluop;
    logic [REGW-1:0] ex_rd;
    logic            ex_regwrite;
    logic            ex_memread;
    logic            ex_memwrite;
    logic [1:0]      ex_wdsel;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_rd,
        output id_rs1_used, id_rs2_used, id_rs1_data, id_rs2_data,
        output id_imm, id_alusrc, id_aluop,
        output id_regwrite, id_memread, id_memwrite, id_wdsel,
        output hold, flush,
        output exmem_regwrite, exmem_rd, exmem_result,
        output memwb_regwrite, memwb_rd, memwb_wdata,
        input  stall, ex_valid, ex_pc, ex_A, ex_B, ex_store_data,
        input  ex_aluop, ex_rd, ex_regwrite, ex_memread, ex_memwrite,
        input  ex_wdsel
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_rd,
        input  id_rs1_used, id_rs2_used, id_rs1_data, id_rs2_data,
        input  id_imm, id_alusrc, id_aluop,
        input  id_regwrite, id_memread, id_memwrite, id_wdsel,
        input  hold, flush,
        input  exmem_regwrite, exmem_rd, exmem_result,
        input  memwb_regwrite, memwb_rd, memwb_wdata,
        output stall, ex_valid, ex_pc, ex_A, ex_B, ex_store_data,
        output ex_aluop, ex_rd, ex_regwrite, ex_memread, ex_memwrite,
        output ex_wdsel
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side forwarding and hazard stall.
// Ports: clk, rst (async, active-high), bus (id_ex_stage_if.slave):
//   id_* decoded instruction in, hold/flush, EX/MEM and MEM/WB writer taps,
//   stall out, ex_* ALU operands/controls out.
// Macro ID_EX_FORWARD_EN: defined = forwarding + load-use stall only;
//   undefined = no forwarding, stall on any RAW against EX, EX/MEM, MEM/WB.
module id_ex_stage #(
    parameter int             XLEN      = 32,
    parameter int             REGW      = 5,
    parameter int             OPW       = 5,
    parameter logic [OPW-1:0] ALUOP_NOP = '0
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic            alusrc;
        logic [OPW-1:0]  aluop;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic [1:0]      wdsel;
    } ex_reg_t;

    ex_reg_t         ex_q;
    ex_reg_t         ex_d;
    logic            hazard;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    // Does the ID instruction read a register that writer (wr, rd) produces?
    function automatic logic raw_hit(input logic wr, input logic [REGW-1:0] rd);
        return wr && (rd != '0) &&
               ((bus.id_rs1_used && bus.id_rs1 == rd) ||
                (bus.id_rs2_used && bus.id_rs2 == rd));
    endfunction

`ifdef ID_EX_FORWARD_EN
    // Youngest writer wins; x0 is never a forwarding source.
    function automatic logic [XLEN-1:0] fwd(input logic [REGW-1:0] rs,
                                            input logic [XLEN-1:0] rf);
        if (bus.exmem_regwrite && bus.exmem_rd != '0 && bus.exmem_rd == rs)
            return bus.exmem_result;
        else if (bus.memwb_regwrite && bus.memwb_rd != '0 && bus.memwb_rd == rs)
            return bus.memwb_wdata;
        else
            return rf;
    endfunction

    assign rs1_fwd = fwd(ex_q.rs1, ex_q.rs1_data);
    assign rs2_fwd = fwd(ex_q.rs2, ex_q.rs2_data);

    // Only a load in EX cannot be forwarded in time.
    assign hazard = bus.id_valid &&
                    raw_hit(ex_q.valid && ex_q.memread, ex_q.rd);
`else
    logic unused_fwd;
    assign unused_fwd = ^{bus.exmem_result, bus.memwb_wdata, ex_q.rs1, ex_q.rs2};

    assign rs1_fwd = ex_q.rs1_data;
    assign rs2_fwd = ex_q.rs2_data;

    // Without forwarding, wait until every in-flight producer has retired.
    assign hazard = bus.id_valid &&
                    (raw_hit(ex_q.valid && ex_q.regwrite, ex_q.rd) ||
                     raw_hit(bus.exmem_regwrite, bus.exmem_rd) ||
                     raw_hit(bus.memwb_regwrite, bus.memwb_rd));
`endif

    always_comb begin
        ex_d = ex_q;
        if (bus.hold) begin
            ex_d = ex_q;
        end else if (bus.flush || hazard) begin
            ex_d       = '0;
            ex_d.aluop = ALUOP_NOP;
        end else begin
            ex_d.valid    = bus.id_valid;
            ex_d.pc       = bus.id_pc;
            ex_d.rs1      = bus.id_rs1;
            ex_d.rs2      = bus.id_rs2;
            ex_d.rd       = bus.id_rd;
            ex_d.rs1_data = bus.id_rs1_data;
            ex_d.rs2_data = bus.id_rs2_data;
            ex_d.imm      = bus.id_imm;
            ex_d.alusrc   = bus.id_alusrc;
            ex_d.aluop    = bus.id_aluop;
            ex_d.regwrite = bus.id_regwrite;
            ex_d.memread  = bus.id_memread;
            ex_d.memwrite = bus.id_memwrite;
            ex_d.wdsel    = bus.id_wdsel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q       <= '0;
            ex_q.aluop <= ALUOP_NOP;
        end else begin
            ex_q <= ex_d;
        end
    end

    // A flushed ID instruction is discarded, so it never needs to wait.
    assign bus.stall         = hazard && !bus.flush;
    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_pc         = ex_q.pc;
    assign bus.ex_A          = rs1_fwd;
    assign bus.ex_B          = ex_q.alusrc ? ex_q.imm : rs2_fwd;
    assign bus.ex_store_data = rs2_fwd;
    assign bus.ex_aluop      = ex_q.aluop;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.ex_regwrite   = ex_q.valid && ex_q.regwrite;
    assign bus.ex_memread    = ex_q.valid && ex_q.memread;
    assign bus.ex_memwrite   = ex_q.valid && ex_q.memwrite;
    assign bus.ex_wdsel      = ex_q.wdsel;
endmodule
